// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA raster timing constants, phase/run enums and phase lookup
package vga_pkg;

   // 640x480 @ 60 Hz defaults, shared with the pixel generator
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // Both raster counters are 10 bits wide
   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FRONT,
      PH_SYNC,
      PH_BACK
   } porch_phase_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } run_state_t;

   // Phase of a position along one axis; everything past the sync pulse is back porch
   function automatic porch_phase_t phase_of(input int count, input int active,
                                             input int front, input int sync_w);
      if (count < active)
         return PH_ACTIVE;
      else if (count < active + front)
         return PH_FRONT;
      else if (count < active + front + sync_w)
         return PH_SYNC;
      else
         return PH_BACK;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with porch phase and sync flag
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FRONT  = DEF_H_FRONT,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BACK   = DEF_H_BACK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output porch_phase_t     phase,
   output logic             sync,
   output logic             wrap
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] count_next;

   // wrap flags that the next step returns the axis to 0
   assign wrap = (count == LAST);

   // Next position; phase describes the position being loaded, so the parent
   // can register flags in step with the count
   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (step)
         count_next = wrap ? '0 : count + CNT_W'(1);
      phase = phase_of(int'(count_next), ACTIVE, FRONT, SYNC);
   end

   // Count and sync flag change on the same edge, so sync never lags the position
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         sync  <= 1'b0;
      end else begin
         count <= count_next;
         sync  <= (phase == PH_SYNC);
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster sequencer with pixel strobe and frame-granular run control
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             enable,
   output logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start,
   output logic             busy
);

   logic         toggle;
   run_state_t   state;
   logic         h_step;
   logic         v_step;
   logic         axis_clear;
   logic         h_wrap;
   logic         v_wrap;
   logic         h_sync;
   logic         v_sync;
   logic         frame_end;
   porch_phase_t h_phase;
   porch_phase_t v_phase;

   // Counters only move while a frame is running; idle holds them at the origin
   assign h_step     = toggle && (state == ST_RUN);
   assign v_step     = h_step && h_wrap;
   assign axis_clear = (state == ST_IDLE);
   assign frame_end  = h_wrap && v_wrap;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE),
      .FRONT (H_FRONT),
      .SYNC  (H_SYNC),
      .BACK  (H_BACK)
   ) u_h_counter (
      .clk  (clk_50),
      .reset(reset),
      .step (h_step),
      .clear(axis_clear),
      .count(pixel_x),
      .phase(h_phase),
      .sync (h_sync),
      .wrap (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE),
      .FRONT (V_FRONT),
      .SYNC  (V_SYNC),
      .BACK  (V_BACK)
   ) u_v_counter (
      .clk  (clk_50),
      .reset(reset),
      .step (v_step),
      .clear(axis_clear),
      .count(pixel_y),
      .phase(v_phase),
      .sync (v_sync),
      .wrap (v_wrap)
   );

   // Sync flags are registered in the counters; only the constant polarity is applied here
   assign hsync = h_sync ~^ SYNC_POL;
   assign vsync = v_sync ~^ SYNC_POL;

   // Pixel strobe, run/stop FSM and registered flags, all updated on the pixel edge
   always_ff @(posedge clk_50) begin
      if (reset) begin
         toggle      <= 1'b0;
         pix_en      <= 1'b0;
         state       <= ST_IDLE;
         busy        <= 1'b0;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         toggle      <= ~toggle;
         pix_en      <= toggle;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (toggle) begin
            case (state)
               ST_IDLE: begin
                  if (enable) begin
                     state       <= ST_RUN;
                     busy        <= 1'b1;
                     video_on    <= 1'b1;
                     line_start  <= 1'b1;
                     frame_start <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (frame_end && !enable) begin
                     state    <= ST_IDLE;
                     busy     <= 1'b0;
                     video_on <= 1'b0;
                  end else begin
                     video_on    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
                     line_start  <= h_wrap;
                     frame_start <= frame_end;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable_d = 1'b0;
   logic       enable_s = 1'b0;

   logic       pe_d, hs_d, vs_d, von_d, ls_d, fs_d, busy_d;
   logic [9:0] x_d, y_d;
   logic       pe_s, hs_s, vs_s, von_s, ls_s, fs_s, busy_s;
   logic [9:0] x_s, y_s;

   int n_cmp = 0;
   int n_fail = 0;

   // small-raster model position, carried from one scenario into the next
   int mx = 0;
   int my = 0;

   always #10 clk = ~clk;

   vga_timing_ctrl dut_d (
      .clk_50     (clk),
      .reset      (reset),
      .enable     (enable_d),
      .pix_en     (pe_d),
      .hsync      (hs_d),
      .vsync      (vs_d),
      .video_on   (von_d),
      .pixel_x    (x_d),
      .pixel_y    (y_d),
      .line_start (ls_d),
      .frame_start(fs_d),
      .busy       (busy_d)
   );

   vga_timing_ctrl #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut_s (
      .clk_50     (clk),
      .reset      (reset),
      .enable     (enable_s),
      .pix_en     (pe_s),
      .hsync      (hs_s),
      .vsync      (vs_s),
      .video_on   (von_s),
      .pixel_x    (x_s),
      .pixel_y    (y_s),
      .line_start (ls_s),
      .frame_start(fs_s),
      .busy       (busy_s)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({pe_d, hs_d, vs_d, von_d, ls_d, fs_d, busy_d} !== 7'b0110000 || x_d !== 10'd0 || y_d !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_default: flags pe/hs/vs/von/ls/fs/busy=%b x=%0d y=%0d, expected 0110000 x=0 y=0",
                  {pe_d, hs_d, vs_d, von_d, ls_d, fs_d, busy_d}, x_d, y_d);
      end
      n_cmp++;
      if ({pe_s, hs_s, vs_s, von_s, ls_s, fs_s, busy_s} !== 7'b0110000 || x_s !== 10'd0 || y_s !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_small: flags=%b x=%0d y=%0d, expected 0110000 x=0 y=0",
                  {pe_s, hs_s, vs_s, von_s, ls_s, fs_s, busy_s}, x_s, y_s);
      end
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (pe_d !== ((k % 2) == 0)) begin
            n_fail++;
            $display("FAIL pix_en_cadence: cycle %0d after release got %b expected %b", k, pe_d, ((k % 2) == 0));
         end
      end
   endtask

   task automatic test_line_default();
      int   lat;
      int   bad_pe, bad_x, hs_cnt, hs_first, hs_last, von_cnt, ls_at;
      logic pe;
      lat = 0;
      enable_d = 1'b1;
      for (int k = 1; k <= 3 && lat == 0; k++) begin
         @(negedge clk);
         if (fs_d === 1'b1) lat = k;
      end
      n_cmp++;
      if (lat == 0 || lat > 2) begin
         n_fail++;
         $display("FAIL enable_latency: frame_start after %0d cycles (0=never), required 1..2", lat);
      end
      n_cmp++;
      if (x_d !== 10'd0 || y_d !== 10'd0 || {pe_d, ls_d, busy_d, von_d, hs_d, vs_d} !== 6'b111111) begin
         n_fail++;
         $display("FAIL first_pixel: x=%0d y=%0d pe/ls/busy/von/hs/vs=%b, expected 0 0 111111",
                  x_d, y_d, {pe_d, ls_d, busy_d, von_d, hs_d, vs_d});
      end
      mx = 0; bad_pe = 0; bad_x = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; von_cnt = 1; ls_at = -1;
      for (int c = 1; c <= 1600; c++) begin
         @(negedge clk);
         pe = ((c % 2) == 0);
         if (pe) mx = (mx + 1) % 800;
         if (pe_d !== pe) bad_pe++;
         if (x_d !== 10'(mx)) bad_x++;
         if (pe_d === 1'b1 && hs_d === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(x_d);
            hs_last = int'(x_d);
         end
         if (pe_d === 1'b1 && von_d === 1'b1 && c < 1600) von_cnt++;
         if (ls_d === 1'b1 && ls_at < 0) ls_at = c;
      end
      n_cmp++;
      if (bad_pe != 0) begin n_fail++; $display("FAIL line_pix_en: %0d bad cycles, required 0", bad_pe); end
      n_cmp++;
      if (bad_x != 0) begin n_fail++; $display("FAIL line_pixel_x: %0d bad cycles, required 0", bad_x); end
      n_cmp++;
      if (hs_cnt != 96) begin n_fail++; $display("FAIL hsync_width: %0d pixels, required 96", hs_cnt); end
      n_cmp++;
      if (hs_first != 656 || hs_last != 751) begin
         n_fail++;
         $display("FAIL hsync_span: x=%0d..%0d, required 656..751", hs_first, hs_last);
      end
      n_cmp++;
      if (von_cnt != 640) begin n_fail++; $display("FAIL line_video_on: %0d pixels, required 640", von_cnt); end
      n_cmp++;
      if (ls_at != 1600) begin n_fail++; $display("FAIL line_period: next line_start at %0d, required 1600", ls_at); end
      n_cmp++;
      if (y_d !== 10'd1 || x_d !== 10'd0) begin
         n_fail++;
         $display("FAIL second_line: x=%0d y=%0d, required 0 1", x_d, y_d);
      end
      enable_d = 1'b0;
   endtask

   task automatic test_small_frames();
      int   found;
      int   bad_pe, bad_xy, bad_sync, bad_von, bad_pulse, bad_busy;
      int   fs_n, fs_first, von_n, hs_n;
      logic pe;
      found = 0;
      enable_s = 1'b1;
      for (int k = 1; k <= 4 && found == 0; k++) begin
         @(negedge clk);
         if (fs_s === 1'b1) found = k;
      end
      n_cmp++;
      if (found == 0 || x_s !== 10'd0 || y_s !== 10'd0 || {ls_s, busy_s, von_s, hs_s, vs_s} !== 5'b11111) begin
         n_fail++;
         $display("FAIL small_start: seen=%0d x=%0d y=%0d ls/busy/von/hs/vs=%b, expected start at 0 0 11111",
                  found, x_s, y_s, {ls_s, busy_s, von_s, hs_s, vs_s});
      end
      mx = 0; my = 0;
      bad_pe = 0; bad_xy = 0; bad_sync = 0; bad_von = 0; bad_pulse = 0; bad_busy = 0;
      fs_n = 0; fs_first = -1; von_n = 0; hs_n = 0;
      for (int c = 1; c <= 392; c++) begin
         @(negedge clk);
         pe = ((c % 2) == 0);
         if (pe) begin
            mx++;
            if (mx == 14) begin mx = 0; my = (my + 1) % 7; end
         end
         if (pe_s !== pe) bad_pe++;
         if (x_s !== 10'(mx) || y_s !== 10'(my)) bad_xy++;
         if (hs_s !== !(mx >= 10 && mx <= 11) || vs_s !== (my != 5)) bad_sync++;
         if (von_s !== (mx < 8 && my < 4)) bad_von++;
         if (ls_s !== (pe && mx == 0) || fs_s !== (pe && mx == 0 && my == 0)) bad_pulse++;
         if (busy_s !== 1'b1) bad_busy++;
         if (fs_s === 1'b1) begin
            fs_n++;
            if (fs_first < 0) fs_first = c;
         end
         if (pe_s === 1'b1 && von_s === 1'b1) von_n++;
         if (pe_s === 1'b1 && hs_s === 1'b0) hs_n++;
      end
      n_cmp++;
      if (bad_pe != 0) begin n_fail++; $display("FAIL small_pix_en: %0d bad cycles, required 0", bad_pe); end
      n_cmp++;
      if (bad_xy != 0) begin n_fail++; $display("FAIL small_xy: %0d bad cycles, required 0", bad_xy); end
      n_cmp++;
      if (bad_sync != 0) begin n_fail++; $display("FAIL small_syncs: %0d bad cycles, required 0", bad_sync); end
      n_cmp++;
      if (bad_von != 0) begin n_fail++; $display("FAIL small_video_on: %0d bad cycles, required 0", bad_von); end
      n_cmp++;
      if (bad_pulse != 0) begin n_fail++; $display("FAIL small_pulses: %0d bad cycles, required 0", bad_pulse); end
      n_cmp++;
      if (bad_busy != 0) begin n_fail++; $display("FAIL small_busy: %0d bad cycles, required 0", bad_busy); end
      n_cmp++;
      if (fs_n != 2 || fs_first != 196) begin
         n_fail++;
         $display("FAIL small_frame_period: %0d frame_starts first at %0d, required 2 at 196", fs_n, fs_first);
      end
      n_cmp++;
      if (von_n != 64) begin n_fail++; $display("FAIL small_video_count: %0d pixels, required 64", von_n); end
      n_cmp++;
      if (hs_n != 28) begin n_fail++; $display("FAIL small_hsync_count: %0d pixels, required 28", hs_n); end
   endtask

   task automatic test_enable_drop();
      int   bad_xy, bad_sync, bad_von, bad_pulse, bad_busy;
      int   idle_at, last_bx, last_by, fs_after;
      logic pe, m_run, dropped;
      bad_xy = 0; bad_sync = 0; bad_von = 0; bad_pulse = 0; bad_busy = 0;
      idle_at = -1; last_bx = -1; last_by = -1; fs_after = 0;
      m_run = 1'b1; dropped = 1'b0;
      for (int c = 393; c <= 788; c++) begin
         @(negedge clk);
         pe = ((c % 2) == 0);
         if (pe && m_run) begin
            if (mx == 13 && my == 6 && dropped) begin
               m_run = 1'b0; mx = 0; my = 0; idle_at = c;
            end else begin
               mx++;
               if (mx == 14) begin mx = 0; my = (my + 1) % 7; end
            end
         end
         if (x_s !== 10'(mx) || y_s !== 10'(my)) bad_xy++;
         if (hs_s !== !(m_run && mx >= 10 && mx <= 11) || vs_s !== !(m_run && my == 5)) bad_sync++;
         if (von_s !== (m_run && mx < 8 && my < 4)) bad_von++;
         if (ls_s !== (m_run && pe && mx == 0) || fs_s !== (m_run && pe && mx == 0 && my == 0)) bad_pulse++;
         if (busy_s !== m_run) bad_busy++;
         if (busy_s === 1'b1 && pe_s === 1'b1) begin last_bx = int'(x_s); last_by = int'(y_s); end
         if (fs_s === 1'b1) fs_after++;
         if (pe && m_run && my == 2 && mx == 0 && !dropped) begin
            enable_s = 1'b0;
            dropped = 1'b1;
         end
      end
      n_cmp++;
      if (bad_xy != 0) begin n_fail++; $display("FAIL drop_xy: %0d bad cycles, required 0", bad_xy); end
      n_cmp++;
      if (bad_sync != 0) begin n_fail++; $display("FAIL drop_syncs: %0d bad cycles, required 0", bad_sync); end
      n_cmp++;
      if (bad_von != 0) begin n_fail++; $display("FAIL drop_video_on: %0d bad cycles, required 0", bad_von); end
      n_cmp++;
      if (bad_pulse != 0) begin n_fail++; $display("FAIL drop_pulses: %0d bad cycles, required 0", bad_pulse); end
      n_cmp++;
      if (bad_busy != 0) begin n_fail++; $display("FAIL drop_busy: %0d bad cycles, required 0", bad_busy); end
      n_cmp++;
      if (idle_at != 588) begin n_fail++; $display("FAIL drop_idle_time: idle at %0d, required 588", idle_at); end
      n_cmp++;
      if (last_bx != 13 || last_by != 6) begin
         n_fail++;
         $display("FAIL drop_last_pixel: last busy pixel (%0d,%0d), required (13,6)", last_bx, last_by);
      end
      n_cmp++;
      if (fs_after != 0) begin n_fail++; $display("FAIL drop_no_restart: %0d frame_starts, required 0", fs_after); end
   endtask

   task automatic test_mid_reset();
      int   found, hit, lat, hs_n, hs_min, hs_max, fs_at, bad_xy;
      logic pe;
      found = 0; hit = 0; lat = 0;
      enable_s = 1'b1;
      for (int k = 1; k <= 4 && found == 0; k++) begin
         @(negedge clk);
         if (fs_s === 1'b1) found = k;
      end
      for (int k = 1; k <= 400 && hit == 0; k++) begin
         @(negedge clk);
         if (pe_s === 1'b1 && x_s === 10'd5 && y_s === 10'd3) hit = k;
      end
      n_cmp++;
      if (found == 0 || hit == 0) begin
         n_fail++;
         $display("FAIL mid_reset_reach: start=%0d reach=%0d, required both nonzero", found, hit);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({pe_s, hs_s, vs_s, von_s, ls_s, fs_s, busy_s} !== 7'b0110000 || x_s !== 10'd0 || y_s !== 10'd0) begin
         n_fail++;
         $display("FAIL mid_reset_small: flags=%b x=%0d y=%0d, expected 0110000 x=0 y=0",
                  {pe_s, hs_s, vs_s, von_s, ls_s, fs_s, busy_s}, x_s, y_s);
      end
      n_cmp++;
      if ({pe_d, hs_d, vs_d, von_d, ls_d, fs_d, busy_d} !== 7'b0110000 || x_d !== 10'd0 || y_d !== 10'd0) begin
         n_fail++;
         $display("FAIL mid_reset_default: flags=%b x=%0d y=%0d, expected 0110000 x=0 y=0",
                  {pe_d, hs_d, vs_d, von_d, ls_d, fs_d, busy_d}, x_d, y_d);
      end
      reset = 1'b0;
      for (int k = 1; k <= 4 && lat == 0; k++) begin
         @(negedge clk);
         if (fs_s === 1'b1) lat = k;
      end
      n_cmp++;
      if (lat != 2) begin n_fail++; $display("FAIL restart_latency: frame_start at cycle %0d, required 2", lat); end
      mx = 0; my = 0; hs_n = 0; hs_min = 99; hs_max = -1; fs_at = -1; bad_xy = 0;
      for (int c = 1; c <= 196; c++) begin
         @(negedge clk);
         pe = ((c % 2) == 0);
         if (pe) begin
            mx++;
            if (mx == 14) begin mx = 0; my = (my + 1) % 7; end
         end
         if (x_s !== 10'(mx) || y_s !== 10'(my)) bad_xy++;
         if (c < 28 && pe_s === 1'b1 && hs_s === 1'b0) begin
            hs_n++;
            if (int'(x_s) < hs_min) hs_min = int'(x_s);
            if (int'(x_s) > hs_max) hs_max = int'(x_s);
         end
         if (fs_s === 1'b1 && fs_at < 0) fs_at = c;
      end
      n_cmp++;
      if (bad_xy != 0) begin n_fail++; $display("FAIL restart_xy: %0d bad cycles, required 0", bad_xy); end
      n_cmp++;
      if (hs_n != 2 || hs_min != 10 || hs_max != 11) begin
         n_fail++;
         $display("FAIL restart_hsync: %0d pixels x=%0d..%0d, required 2 pixels x=10..11", hs_n, hs_min, hs_max);
      end
      n_cmp++;
      if (fs_at != 196) begin n_fail++; $display("FAIL restart_frame_period: next frame_start at %0d, required 196", fs_at); end
      enable_s = 1'b0;
   endtask

   initial begin
      test_reset();
      test_line_default();
      test_small_frames();
      test_enable_drop();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA raster. Runs from the 50 MHz board clock, produces its own 25 MHz pixel-enable strobe and steps horizontal and vertical counters through active, front-porch, sync and back-porch phases. Emits hsync, vsync, blanking and pixel coordinates to the pixel generator and DAC output stage. Also provides a frame-granular run/stop control so downstream logic never sees a truncated frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

- clk_50  in  1  50 MHz system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; sampled only at frame boundaries (see Operation)
- pix_en  out  1  one-cycle strobe every second clk_50 cycle (25 MHz pixel rate)
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse coincident with pix_en when pixel_x becomes 0
- frame_start  out  1  one-cycle pulse coincident with pix_en when pixel_x and pixel_y both become 0
- busy  out  1  high while a frame is in progress

## Operation
- H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525); both must fit in 10 bits.
- Phase toggle divides clk_50 by 2; pix_en is high on the clk_50 cycle where the toggle is 1. Counters advance only on pix_en cycles.
- Horizontal FSM, per pixel: ACTIVE (x < H_ACTIVE), FRONT, SYNC, BACK, and back to ACTIVE at x = H_TOTAL-1 → 0. The vertical FSM has the same four states and advances by one line on each horizontal wrap.
- hsync is asserted for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (656..751). vsync is asserted for y in [490, 491]. Otherwise both are at the deasserted level (~SYNC_POL).
- Top-level states:
  - IDLE: counters held at 0, syncs deasserted, video_on=0, busy=0.
  - RUN: entered from IDLE on the first pix_en with enable=1. The first pixel (0,0) is presented with frame_start=1.
- In RUN, enable is sampled on the pix_en where the counters wrap from (H_TOTAL-1, V_TOTAL-1):
  - enable=1: continue into the next frame with frame_start.
  - enable=0: go to IDLE.
- Dropping enable mid-frame never truncates the frame.
- Simultaneous horizontal and vertical wrap: pixel_y returns to 0 and frame_start and line_start both pulse.
- Reset at any point: immediate return to IDLE with all outputs at reset values on the next edge. The phase toggle restarts.

## Timing
- Reset values: pix_en=0, hsync=vsync=~SYNC_POL, video_on=0, pixel_x=pixel_y=0, line_start=frame_start=0, busy=0.
- First pix_en is on the 2nd clk_50 edge after reset deasserts, then every 2 cycles.
- All outputs are registers. On a pix_en edge they reflect the new counter value with zero added latency, and hold for 2 clk_50 cycles.
- One line = 1600 clk_50 cycles. One frame = 840 000 clk_50 cycles.
- enable→first frame_start: at most 2 clk_50 cycles (next pix_en).

## Structure
- Shared package vga_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL, also used by the pixel generator;
  - an enum for porch phases {ACTIVE, FRONT, SYNC, BACK};
  - an enum for run states {IDLE, RUN}.
- One sub-module is natural: vga_axis_counter. It is instantiated twice (horizontal and vertical) and has:
  - parameters ACTIVE/FRONT/SYNC/BACK;
  - inputs step and clear;
  - outputs count, phase, sync and wrap.

## Test plan
- Reset held 5 cycles then released → all outputs at reset values; first pix_en on 2nd cycle; pix_en period exactly 2.
- enable=1 from reset → frame_start at (0,0); hsync low exactly 96 pix_en (x=656..751); line_start every 1600 clk_50 cycles.
- Full frame → vsync low during lines 490–491 only; video_on high for 307 200 pix_en cycles; next frame_start 840 000 cycles after the first.
- enable dropped at y=100 → frame completes through (799,524); busy falls; counters stay at 0 and no further frame_start appears.
- Reset asserted at x=300, y=200 → next edge: pixel_x=pixel_y=0, syncs deasserted, busy=0; restart with enable yields a correct frame.
- Parameter override (H_ACTIVE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_*=4/1/1/1) → hsync covers x=10..11; line length 14 pixels; frame length 98 pixels.
